// File: rtl/draw_pkg.sv
// Shared definitions for the frame-redraw scheduler: FSM states,
// xy-word field positions and the sprite id -> colour palette.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        OBJ,
        DONE
    } state_t;

    localparam int XY_X_MSB = 16;
    localparam int XY_X_LSB = 8;
    localparam int XY_Y_MSB = 7;
    localparam int XY_Y_LSB = 0;

    // {R4,G4,B4} colour for a sprite id.
    function automatic logic [11:0] palette(input logic [4:0] id);
        return {id[3:0], ~id[3:0], id[4:1] ^ 4'h5};
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Pixel-write bus toward the VGA adapter plus frame status.
// master: scheduler drives x/y/colour/plot/busy/done; slave: adapter side.
interface draw_scheduler_if;

    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (output x, y, colour, plot, busy, done);
    modport slave  (input  x, y, colour, plot, busy, done);

endinterface

// File: rtl/draw_scheduler_raster.sv
// raster_counter_2d: x-inner / y-outer raster counter with run-time bounds.
// Ports: clk, rst_n, clear (sync to 0), enable (step), w_lim/h_lim (last
// coordinate), cx/cy (position), last (cx==w_lim && cy==h_lim).
module raster_counter_2d #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [XW-1:0] w_lim,
    input  logic [YW-1:0] h_lim,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    assign last = (cx == w_lim) && (cy == h_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cx == w_lim) begin
                cx <= '0;
                cy <= (cy == h_lim) ? '0 : cy + YW'(1);
            end else begin
                cx <= cx + XW'(1);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: one frame redraw = background clear, then filled square
// sprites in list order, serialised onto the VGA pixel-write port.
// Ports: CLOCK_50, resetn (async, low), start, background, ob1a..ob3a,
// ob1axy..ob3axy, ob1b..ob3b, ob1bxy..ob3bxy, vga (x/y/colour/plot/busy/done).
// Macro DUAL_LAYER_EN: adds layer-B objects (6-entry list); otherwise the
// b-ports are ignored and no B snapshot registers exist.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int OBJ_SIZE = 8
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic [11:0]       background,
    input  logic [4:0]        ob1a,
    input  logic [4:0]        ob2a,
    input  logic [4:0]        ob3a,
    input  logic [16:0]       ob1axy,
    input  logic [16:0]       ob2axy,
    input  logic [16:0]       ob3axy,
    input  logic [4:0]        ob1b,
    input  logic [4:0]        ob2b,
    input  logic [4:0]        ob3b,
    input  logic [16:0]       ob1bxy,
    input  logic [16:0]       ob2bxy,
    input  logic [16:0]       ob3bxy,
    draw_scheduler_if.master  vga
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
`ifdef DUAL_LAYER_EN
    localparam int N = 6;
`else
    localparam int N = 3;
`endif
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [11:0]   bg_r;
    logic [4:0]    obj_id [N];
    logic [16:0]   obj_xy [N];
    logic [16:0]   cur_xy;
    logic [11:0]   cur_pal;

    logic [8:0]    x_r;
    logic [7:0]    y_r;
    logic [11:0]   colour_r;
    logic          plot_r;
    logic          busy_r;
    logic          done_r;

    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          last;
    logic          cnt_en;
    logic          cnt_clr;
    logic [XW-1:0] w_lim;
    logic [YW-1:0] h_lim;

    logic [9:0]    sx;
    logic [8:0]    sy;
    logic          in_view;

`ifndef DUAL_LAYER_EN
    logic unused_b;
    assign unused_b = ^{ob1b, ob2b, ob3b, ob1bxy, ob2bxy, ob3bxy};
`endif

    // One counter serves both the screen clear and the sprite raster.
    assign cnt_en  = (state == CLEAR) || (state == OBJ);
    assign cnt_clr = (state == IDLE) || (cnt_en && last);
    assign w_lim   = (state == OBJ) ? XW'(OBJ_SIZE - 1) : XW'(SCREEN_W - 1);
    assign h_lim   = (state == OBJ) ? YW'(OBJ_SIZE - 1) : YW'(SCREEN_H - 1);

    raster_counter_2d #(
        .WIDTH  (SCREEN_W),
        .HEIGHT (SCREEN_H)
    ) u_raster (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .w_lim  (w_lim),
        .h_lim  (h_lim),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    // One bit wider than the pixel bus so off-screen sums clip, never wrap.
    assign sx = {1'b0, cur_xy[XY_X_MSB:XY_X_LSB]} + 10'(cx);
    assign sy = {1'b0, cur_xy[XY_Y_MSB:XY_Y_LSB]} + 9'(cy);
    assign in_view = (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= '0;
            bg_r     <= '0;
            cur_xy   <= '0;
            cur_pal  <= '0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                obj_id[i] <= '0;
                obj_xy[i] <= '0;
            end
        end else begin
            plot_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= (state != IDLE) || start;
            case (state)
                IDLE: begin
                    if (start) begin
                        bg_r      <= background;
                        obj_id[0] <= ob1a;
                        obj_id[1] <= ob2a;
                        obj_id[2] <= ob3a;
                        obj_xy[0] <= ob1axy;
                        obj_xy[1] <= ob2axy;
                        obj_xy[2] <= ob3axy;
`ifdef DUAL_LAYER_EN
                        obj_id[3] <= ob1b;
                        obj_id[4] <= ob2b;
                        obj_id[5] <= ob3b;
                        obj_xy[3] <= ob1bxy;
                        obj_xy[4] <= ob2bxy;
                        obj_xy[5] <= ob3bxy;
`endif
                        idx   <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    plot_r   <= 1'b1;
                    x_r      <= 9'(cx);
                    y_r      <= 8'(cy);
                    colour_r <= bg_r;
                    if (last) state <= LOAD;
                end
                LOAD: begin
                    cur_xy  <= obj_xy[idx];
                    cur_pal <= palette(obj_id[idx]);
                    if (obj_id[idx] != 5'd0) begin
                        state <= OBJ;
                    end else if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                OBJ: begin
                    plot_r   <= in_view;
                    x_r      <= sx[8:0];
                    y_r      <= sy[7:0];
                    colour_r <= cur_pal;
                    if (last) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vga.x      = x_r;
    assign vga.y      = y_r;
    assign vga.colour = colour_r;
    assign vga.plot   = plot_r;
    assign vga.busy   = busy_r;
    assign vga.done   = done_r;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler on an 8x4 screen with 2x2 sprites.
// Reference frames are built from the drawing rules; a monitor pops them.
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int W = 8;
    localparam int H = 4;
    localparam int S = 2;
`ifdef DUAL_LAYER_EN
    localparam int N = 6;
`else
    localparam int N = 3;
`endif

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [11:0] background;
    logic [4:0]  ida [3];
    logic [4:0]  idb [3];
    logic [16:0] xya [3];
    logic [16:0] xyb [3];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    pix_t exp_pix [$];
    int   exp_done [$];

    draw_scheduler_if vga ();

    draw_scheduler #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .OBJ_SIZE (S)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .start      (start),
        .background (background),
        .ob1a       (ida[0]),
        .ob2a       (ida[1]),
        .ob3a       (ida[2]),
        .ob1axy     (xya[0]),
        .ob2axy     (xya[1]),
        .ob3axy     (xya[2]),
        .ob1b       (idb[0]),
        .ob2b       (idb[1]),
        .ob3b       (idb[2]),
        .ob1bxy     (xyb[0]),
        .ob2bxy     (xyb[1]),
        .ob3bxy     (xyb[2]),
        .vga        (vga)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every plot and every done pulse is matched to the model.
    always @(negedge clk) begin
        pix_t p;
        int   d;
        if (vga.plot === 1'b1) begin
            if (exp_pix.size() == 0) begin
                chk("pixel_extra", {vga.x, vga.y, vga.colour}, 0);
            end else begin
                p = exp_pix.pop_front();
                chk("pixel", {3'b0, vga.x, vga.y, vga.colour}, {3'b0, p});
            end
        end
        if (vga.done === 1'b1) begin
            if (exp_done.size() == 0) begin
                chk("done_extra", 32'(cyc), 0);
            end else begin
                d = exp_done.pop_front();
                chk("done_time", 32'(cyc), 32'(d));
            end
            chk("pixels_left", 32'(exp_pix.size()), 0);
            chk("busy_at_done", {31'b0, vga.busy}, 1);
            chk("plot_at_done", {31'b0, vga.plot}, 0);
            done_seen++;
        end
    end

    function automatic logic [4:0] obj_id(input int k);
        return (k < 3) ? ida[k] : idb[k - 3];
    endfunction

    function automatic logic [16:0] obj_xy(input int k);
        return (k < 3) ? xya[k] : xyb[k - 3];
    endfunction

    // Reference frame from the current inputs; returns start->done latency.
    function automatic int model_frame();
        int lat;
        int ox;
        int oy;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                exp_pix.push_back({9'(xx), 8'(yy), background});
        lat = 1 + W * H;
        for (int k = 0; k < N; k++) begin
            lat += 1;
            if (obj_id(k) != 0) begin
                lat += S * S;
                ox = int'(obj_xy(k)[16:8]);
                oy = int'(obj_xy(k)[7:0]);
                for (int dy = 0; dy < S; dy++)
                    for (int dx = 0; dx < S; dx++)
                        if (ox + dx < W && oy + dy < H)
                            exp_pix.push_back({9'(ox + dx), 8'(oy + dy),
                                               palette(obj_id(k))});
            end
        end
        return lat;
    endfunction

    task automatic clear_objs();
        for (int k = 0; k < 3; k++) begin
            ida[k] = '0;
            idb[k] = '0;
            xya[k] = '0;
            xyb[k] = '0;
        end
    endtask

    task automatic rand_inputs();
        int xv;
        int yv;
        background = 12'($urandom);
        for (int k = 0; k < 6; k++) begin
            xv = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 511)
                                             : $urandom_range(0, 9);
            yv = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(0, 5);
            if (k < 3) begin
                ida[k] = ($urandom_range(0, 2) == 0) ? 5'd0
                                                     : 5'($urandom_range(1, 31));
                xya[k] = {9'(xv), 8'(yv)};
            end else begin
                idb[k-3] = ($urandom_range(0, 2) == 0) ? 5'd0
                                                       : 5'($urandom_range(1, 31));
                xyb[k-3] = {9'(xv), 8'(yv)};
            end
        end
    endtask

    // Issue one frame; optionally disturb start/inputs during the clear.
    task automatic run_frame(input bit disturb);
        int lat;
        int acc;
        int target;
        target = done_seen + 1;
        lat = model_frame();
        @(negedge clk);
        start = 1'b1;
        acc = cyc + 1;
        exp_done.push_back(acc + lat);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (10) @(negedge clk);
            rand_inputs();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 300 && done_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_seen < target)
            chk("done_timeout", 32'(done_seen), 32'(target));
        @(negedge clk);
        chk("busy_idle", {31'b0, vga.busy}, 0);
    endtask

    initial begin
        int acc;
        resetn = 1'b0;
        start = 1'b0;
        background = '0;
        clear_objs();
        repeat (3) @(negedge clk);
        chk("rst_plot", {31'b0, vga.plot}, 0);
        chk("rst_busy", {31'b0, vga.busy}, 0);
        chk("rst_done", {31'b0, vga.done}, 0);
        chk("rst_xyc", {3'b0, vga.x, vga.y, vga.colour}, 0);
        resetn = 1'b1;
        @(negedge clk);

        background = 12'hF00;
        run_frame(1'b0);

        ida[0] = 5'd5;
        xya[0] = {9'd3, 8'd1};
        run_frame(1'b0);

        clear_objs();
        ida[1] = 5'd7;
        xya[1] = {9'd7, 8'd3};
        run_frame(1'b0);

        rand_inputs();
        ida[0] = 5'd9;
        run_frame(1'b1);

        clear_objs();
        ida[2] = 5'd31;
        xya[2] = {9'd511, 8'd255};
        ida[0] = 5'd1;
        xya[0] = {9'd6, 8'd2};
        run_frame(1'b0);

        // Reset in the middle of the first sprite.
        clear_objs();
        ida[0] = 5'd4;
        xya[0] = {9'd2, 8'd1};
        void'(model_frame());
        @(negedge clk);
        start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && cyc < acc + 35; i++) @(negedge clk);
        #1;
        resetn = 1'b0;
        exp_pix.delete();
        exp_done.delete();
        #1;
        chk("arst_plot", {31'b0, vga.plot}, 0);
        chk("arst_busy", {31'b0, vga.busy}, 0);
        chk("arst_done", {31'b0, vga.done}, 0);
        chk("arst_xyc", {3'b0, vga.x, vga.y, vga.colour}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, vga.busy}, 0);
        run_frame(1'b0);

`ifdef DUAL_LAYER_EN
        clear_objs();
        ida[0] = 5'd2;
        idb[0] = 5'd3;
        run_frame(1'b0);
`endif

        for (int f = 0; f < 15; f++) begin
            rand_inputs();
            run_frame(f % 5 == 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
